// File: rtl/matmul_pkg.sv
// Shared defaults and FSM state encoding for the matmul job arbiter.
package matmul_pkg;

  localparam int DEF_W        = 16;
  localparam int DEF_N        = 3;
  localparam int DEF_MAT_BITS = DEF_W * DEF_N * DEF_N;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CLR,
    ST_RUN,
    ST_RESP
  } state_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant; the pointer moves past the winner on each accept.
module rr_arbiter2
  import matmul_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [1:0] i_valid,
  input  logic       i_accept,
  output logic [1:0] o_grant
);

  logic ptr_q;
  logic ptr_d;

  always_comb begin
    o_grant = i_valid;
    if (i_valid == 2'b11) begin
      o_grant = ptr_q ? 2'b10 : 2'b01;
    end
    ptr_d = ptr_q;
    if (i_accept) begin
      ptr_d = ~o_grant[1];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/matmul_job_arbiter.sv
// Shares one matmul engine between two requesters: grant, engine clear, run, respond.
// Optional RUN-state timeout is enabled by defining MATMUL_ARB_TIMEOUT_EN.
module matmul_job_arbiter
  import matmul_pkg::*;
#(
  parameter  int W              = DEF_W,
  parameter  int N              = DEF_N,
  parameter  int CLR_CYCLES     = 2,
  parameter  int TIMEOUT_CYCLES = 64,
  localparam int MAT_BITS       = W * N * N
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [1:0]            i_req_valid,
  output logic [1:0]            o_req_ready,
  input  logic [1:0]            i_req_mode,
  input  logic [2*MAT_BITS-1:0] i_req_A,
  input  logic [2*MAT_BITS-1:0] i_req_B,
  output logic [1:0]            o_rsp_valid,
  input  logic [1:0]            i_rsp_ready,
  output logic [MAT_BITS-1:0]   o_rsp_C,
  output logic                  o_rsp_err,
  output logic                  o_mm_rst,
  output logic                  o_mm_en,
  output logic                  o_mm_mode,
  output logic [MAT_BITS-1:0]   o_mm_A,
  output logic [MAT_BITS-1:0]   o_mm_B,
  input  logic [MAT_BITS-1:0]   i_mm_C,
  input  logic                  i_mm_done,
  output logic                  o_busy,
  output logic                  o_owner
);

  state_e                state_q, state_d;
  logic                  owner_q, owner_d;
  logic                  mode_q, mode_d;
  logic [MAT_BITS-1:0]   a_q, a_d, b_q, b_d, rsp_c_q, rsp_c_d;
  logic                  mm_rst_q, mm_rst_d, mm_en_q, mm_en_d;
  logic [3:0]            clr_cnt_q, clr_cnt_d;
  logic [1:0]            grant;
  logic                  accept;
  logic [MAT_BITS-1:0]   req_a [2];
  logic [MAT_BITS-1:0]   req_b [2];

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_req
      assign req_a[gi]       = i_req_A[gi*MAT_BITS +: MAT_BITS];
      assign req_b[gi]       = i_req_B[gi*MAT_BITS +: MAT_BITS];
      assign o_rsp_valid[gi] = (state_q == ST_RESP) && (owner_q == 1'(gi));
    end
  endgenerate

  rr_arbiter2 u_rr (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_valid  (i_req_valid),
    .i_accept (accept),
    .o_grant  (grant)
  );

  // Grant is only exposed in IDLE, and never while reset is being sampled.
  assign o_req_ready = (state_q == ST_IDLE && !i_rst) ? grant : 2'b00;
  assign accept      = |o_req_ready;

`ifdef MATMUL_ARB_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             rsp_err_q, rsp_err_d;
  assign o_rsp_err = rsp_err_q;
`else
  // Keeps the parameter referenced in builds without the timeout.
  logic [31:0] unused_tmo;
  assign unused_tmo = TIMEOUT_CYCLES;
  assign o_rsp_err  = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    mode_d    = mode_q;
    a_d       = a_q;
    b_d       = b_q;
    rsp_c_d   = rsp_c_q;
    mm_rst_d  = 1'b0;
    mm_en_d   = 1'b0;
    clr_cnt_d = clr_cnt_q;
`ifdef MATMUL_ARB_TIMEOUT_EN
    tmo_cnt_d = tmo_cnt_q;
    rsp_err_d = rsp_err_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d   = ST_CLR;
          owner_d   = grant[1];
          mode_d    = i_req_mode[grant[1]];
          a_d       = req_a[grant[1]];
          b_d       = req_b[grant[1]];
          mm_rst_d  = 1'b1;
          clr_cnt_d = 4'd0;
        end
      end
      ST_CLR: begin
        if (clr_cnt_q == 4'(CLR_CYCLES - 1)) begin
          state_d = ST_RUN;
          mm_en_d = 1'b1;
`ifdef MATMUL_ARB_TIMEOUT_EN
          tmo_cnt_d = '0;
`endif
        end else begin
          clr_cnt_d = clr_cnt_q + 4'd1;
          mm_rst_d  = 1'b1;
        end
      end
      ST_RUN: begin
        mm_en_d = 1'b1;
        if (i_mm_done) begin
          state_d = ST_RESP;
          mm_en_d = 1'b0;
          rsp_c_d = i_mm_C;
`ifdef MATMUL_ARB_TIMEOUT_EN
          rsp_err_d = 1'b0;
        end else if (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
          state_d   = ST_RESP;
          mm_en_d   = 1'b0;
          rsp_c_d   = '0;
          rsp_err_d = 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
`endif
        end
      end
      ST_RESP: begin
        if (i_rsp_ready[owner_q]) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= ST_IDLE;
      owner_q   <= 1'b0;
      mode_q    <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      rsp_c_q   <= '0;
      mm_rst_q  <= 1'b1;
      mm_en_q   <= 1'b0;
      clr_cnt_q <= 4'd0;
`ifdef MATMUL_ARB_TIMEOUT_EN
      tmo_cnt_q <= '0;
      rsp_err_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      mode_q    <= mode_d;
      a_q       <= a_d;
      b_q       <= b_d;
      rsp_c_q   <= rsp_c_d;
      mm_rst_q  <= mm_rst_d;
      mm_en_q   <= mm_en_d;
      clr_cnt_q <= clr_cnt_d;
`ifdef MATMUL_ARB_TIMEOUT_EN
      tmo_cnt_q <= tmo_cnt_d;
      rsp_err_q <= rsp_err_d;
`endif
    end
  end

  assign o_rsp_C   = rsp_c_q;
  assign o_mm_rst  = mm_rst_q;
  assign o_mm_en   = mm_en_q;
  assign o_mm_mode = mode_q;
  assign o_mm_A    = a_q;
  assign o_mm_B    = b_q;
  assign o_busy    = (state_q != ST_IDLE);
  assign o_owner   = owner_q;

endmodule

// File: tb/tb_matmul_job_arbiter.sv
// Directed bench for matmul_job_arbiter with a small behavioural engine model.
module tb_matmul_job_arbiter;
  import matmul_pkg::*;

  localparam int MB = DEF_MAT_BITS;

  logic          i_clk = 1'b0;
  logic          i_rst;
  logic [1:0]    i_req_valid, o_req_ready, i_req_mode;
  logic [2*MB-1:0] i_req_A, i_req_B;
  logic [1:0]    o_rsp_valid, i_rsp_ready;
  logic [MB-1:0] o_rsp_C, o_mm_A, o_mm_B, i_mm_C;
  logic          o_rsp_err, o_mm_rst, o_mm_en, o_mm_mode, i_mm_done, o_busy, o_owner;

  logic [MB-1:0] eng_c;
  logic          eng_auto, done_force;
  logic [3:0]    eng_cnt = 4'd0;

  logic [MB-1:0] a0, b0, a1, b1;
  int n_cmp = 0;
  int n_err = 0;
  int cyc;
  logic seen;
  logic [1:0] exp_g;

  always #5 i_clk = ~i_clk;

  matmul_job_arbiter #(
    .W(DEF_W), .N(DEF_N), .CLR_CYCLES(2), .TIMEOUT_CYCLES(8)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready), .i_req_mode(i_req_mode),
    .i_req_A(i_req_A), .i_req_B(i_req_B),
    .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready),
    .o_rsp_C(o_rsp_C), .o_rsp_err(o_rsp_err),
    .o_mm_rst(o_mm_rst), .o_mm_en(o_mm_en), .o_mm_mode(o_mm_mode),
    .o_mm_A(o_mm_A), .o_mm_B(o_mm_B), .i_mm_C(i_mm_C), .i_mm_done(i_mm_done),
    .o_busy(o_busy), .o_owner(o_owner)
  );

  // Engine model: done pulses on the fourth enabled cycle after a clear.
  always @(posedge i_clk) begin
    if (o_mm_rst || !o_mm_en) eng_cnt <= 4'd0;
    else                      eng_cnt <= eng_cnt + 4'd1;
  end
  assign i_mm_done = (eng_auto && o_mm_en && eng_cnt == 4'd3) || done_force;
  assign i_mm_C    = eng_c;

  task automatic chk(input string tag, input logic [MB-1:0] obs, input logic [MB-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic wait_rsp();
    for (int i = 0; i < 40; i++) begin
      if (o_rsp_valid != 2'b00) break;
      step();
    end
  endtask

  task automatic wait_en();
    for (int i = 0; i < 40; i++) begin
      if (o_mm_en) break;
      step();
    end
  endtask

  initial begin
    a0 = {9{16'h3c00}}; b0 = {9{16'h3c00}};
    a1 = {9{16'h4000}}; b1 = {9{16'h3800}};
    i_rst = 1'b1; i_req_valid = 2'b11; i_req_mode = 2'b00;
    i_req_A = '0; i_req_B = '0; i_rsp_ready = 2'b00;
    eng_c = '0; eng_auto = 1'b1; done_force = 1'b0;
    step(); step();

    // Reset state, with both requests pending to show the grant is masked.
    chk("rst_mm_rst", MB'(o_mm_rst), MB'(1'b1));
    chk("rst_mm_en", MB'(o_mm_en), MB'(1'b0));
    chk("rst_busy", MB'(o_busy), MB'(1'b0));
    chk("rst_owner", MB'(o_owner), MB'(1'b0));
    chk("rst_rsp_valid", MB'(o_rsp_valid), MB'(2'b00));
    chk("rst_req_ready", MB'(o_req_ready), MB'(2'b00));
    chk("rst_rsp_c", o_rsp_C, '0);
    chk("rst_rsp_err", MB'(o_rsp_err), MB'(1'b0));
    chk("rst_mm_a", o_mm_A, '0);
    chk("rst_mm_mode", MB'(o_mm_mode), MB'(1'b0));
    i_req_valid = 2'b00; i_rst = 1'b0;
    step();
    chk("post_rst_mm_rst", MB'(o_mm_rst), MB'(1'b0));

    // Spurious done while idle.
    done_force = 1'b1; step(); done_force = 1'b0;
    chk("spur_busy", MB'(o_busy), MB'(1'b0));
    chk("spur_rsp_valid", MB'(o_rsp_valid), MB'(2'b00));
    chk("spur_mm_en", MB'(o_mm_en), MB'(1'b0));

    // Requester 0, all-ones fp16 operands, mode 1; 3-term dot product = 3.0.
    i_req_A = {a1, a0}; i_req_B = {b1, b0}; i_req_mode = 2'b01;
    eng_c = {9{16'h4200}}; i_req_valid = 2'b01; #1;
    chk("j1_ready", MB'(o_req_ready), MB'(2'b01));
    step(); i_req_valid = 2'b00;
    chk("j1_busy", MB'(o_busy), MB'(1'b1));
    chk("j1_clr0_rst", MB'(o_mm_rst), MB'(1'b1));
    chk("j1_clr0_en", MB'(o_mm_en), MB'(1'b0));
    step();
    chk("j1_clr1_rst", MB'(o_mm_rst), MB'(1'b1));
    step();
    chk("j1_run_rst", MB'(o_mm_rst), MB'(1'b0));
    chk("j1_run_en", MB'(o_mm_en), MB'(1'b1));
    chk("j1_run_mode", MB'(o_mm_mode), MB'(1'b1));
    chk("j1_run_a", o_mm_A, a0);
    chk("j1_run_b", o_mm_B, b0);
    wait_rsp();
    chk("j1_rsp_valid", MB'(o_rsp_valid), MB'(2'b01));
    for (int e = 0; e < 9; e++) chk("j1_rsp_elem", MB'(o_rsp_C[e*16 +: 16]), MB'(16'h4200));
    chk("j1_rsp_err", MB'(o_rsp_err), MB'(1'b0));
    chk("j1_resp_en", MB'(o_mm_en), MB'(1'b0));
    i_rsp_ready = 2'b01; step(); i_rsp_ready = 2'b00;
    chk("j1_done_valid", MB'(o_rsp_valid), MB'(2'b00));
    chk("j1_done_busy", MB'(o_busy), MB'(1'b0));
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin seen |= (o_rsp_valid != 2'b00); step(); end
    chk("j1_single_rsp", MB'(seen), MB'(1'b0));

    // Both requesting together: grant order 0, 1, 0.
    i_rst = 1'b1; step(); i_rst = 1'b0; step();
    i_req_mode = 2'b10; i_req_valid = 2'b11; #1;
    for (int k = 0; k < 3; k++) begin
      exp_g = (k == 1) ? 2'b10 : 2'b01;
      eng_c = MB'(k + 100);
      for (int i = 0; i < 40; i++) begin
        if (o_req_ready != 2'b00) break;
        step();
      end
      chk("rr_grant", MB'(o_req_ready), MB'(exp_g));
      step();
      chk("rr_owner", MB'(o_owner), MB'(exp_g[1]));
      wait_en();
      chk("rr_mm_a", o_mm_A, exp_g[1] ? a1 : a0);
      chk("rr_mm_mode", MB'(o_mm_mode), MB'(exp_g[1]));
      wait_rsp();
      chk("rr_rsp_valid", MB'(o_rsp_valid), MB'(exp_g));
      chk("rr_rsp_c", o_rsp_C, MB'(k + 100));
      i_rsp_ready = exp_g; step(); i_rsp_ready = 2'b00;
    end
    i_req_valid = 2'b00;
    step();

    // Response back-pressure from requester 1 while requester 0 waits.
    eng_c = {9{16'hbeef}}; i_req_valid = 2'b10; #1;
    chk("bp_ready", MB'(o_req_ready), MB'(2'b10));
    step(); i_req_valid = 2'b01;
    wait_rsp();
    chk("bp_rsp_valid", MB'(o_rsp_valid), MB'(2'b10));
    for (int i = 0; i < 10; i++) begin
      chk("bp_hold_valid", MB'(o_rsp_valid), MB'(2'b10));
      chk("bp_hold_c", o_rsp_C, {9{16'hbeef}});
      chk("bp_no_grant", MB'(o_req_ready), MB'(2'b00));
      step();
    end
    i_rsp_ready = 2'b01; step();
    chk("bp_nonowner_ignored", MB'(o_rsp_valid), MB'(2'b10));
    i_rsp_ready = 2'b10; step(); i_rsp_ready = 2'b00;
    chk("bp_released", MB'(o_rsp_valid), MB'(2'b00));
    chk("bp_next_grant", MB'(o_req_ready), MB'(2'b01));
    step(); i_req_valid = 2'b00;
    wait_rsp();
    chk("bp_next_rsp", MB'(o_rsp_valid), MB'(2'b01));
    i_rsp_ready = 2'b01; step(); i_rsp_ready = 2'b00;

    // Reset pulse in the middle of RUN.
    eng_c = {9{16'h5555}}; i_req_valid = 2'b01; #1;
    step(); i_req_valid = 2'b00;
    wait_en();
    chk("mid_run_en", MB'(o_mm_en), MB'(1'b1));
    i_rst = 1'b1; step(); i_rst = 1'b0;
    chk("mid_busy", MB'(o_busy), MB'(1'b0));
    chk("mid_en", MB'(o_mm_en), MB'(1'b0));
    chk("mid_rsp_valid", MB'(o_rsp_valid), MB'(2'b00));
    step();
    chk("mid_mm_rst", MB'(o_mm_rst), MB'(1'b0));
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin seen |= (o_rsp_valid != 2'b00); step(); end
    chk("mid_no_rsp", MB'(seen), MB'(1'b0));
    eng_c = {9{16'h7777}}; i_req_valid = 2'b10; #1;
    chk("mid_next_ready", MB'(o_req_ready), MB'(2'b10));
    step(); i_req_valid = 2'b00;
    wait_rsp();
    chk("mid_next_valid", MB'(o_rsp_valid), MB'(2'b10));
    chk("mid_next_c", o_rsp_C, {9{16'h7777}});
    chk("mid_next_err", MB'(o_rsp_err), MB'(1'b0));
    i_rsp_ready = 2'b10; step(); i_rsp_ready = 2'b00;

`ifdef MATMUL_ARB_TIMEOUT_EN
    // Engine never finishes: timeout response 8 cycles into RUN.
    eng_auto = 1'b0; eng_c = {9{16'hffff}}; i_req_valid = 2'b01; #1;
    step(); i_req_valid = 2'b00;
    wait_en();
    cyc = 0;
    for (int i = 0; i < 30; i++) begin
      if (o_rsp_valid != 2'b00) break;
      step(); cyc++;
    end
    chk("tmo_cycles", MB'(cyc), MB'(8));
    chk("tmo_valid", MB'(o_rsp_valid), MB'(2'b01));
    chk("tmo_err", MB'(o_rsp_err), MB'(1'b1));
    chk("tmo_c", o_rsp_C, '0);
    i_rsp_ready = 2'b01; step(); i_rsp_ready = 2'b00;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
